// File: rtl/make_reset_seq_if.sv
// Request/status bundle for make_reset_seq: per-channel requests in, reset levels and release status out.
interface make_reset_seq_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] ASSERT_IN;
    logic [NCH-1:0] ASSERT_OUT;
    logic [NCH-1:0] OUT_RST_N;
    logic           ALL_RELEASED;

    modport master (
        output ASSERT_IN,
        input  ASSERT_OUT,
        input  OUT_RST_N,
        input  ALL_RELEASED
    );

    modport slave (
        input  ASSERT_IN,
        output ASSERT_OUT,
        output OUT_RST_N,
        output ALL_RELEASED
    );
endinterface

// File: rtl/make_reset_seq.sv
// Multi-channel reset generator: each channel holds for at least HOLD cycles after its request drops.
// Define MAKE_RESET_SEQ_EN to force channels to release in index order.
module make_reset_seq #(
    parameter int             NCH  = 4,
    parameter int             HOLD = 8,
    parameter logic [NCH-1:0] INIT = '1
) (
    input logic              CLK,
    input logic              RST,
    make_reset_seq_if.slave  bus
);
    // HOLD=0 behaves as 1, so the counter is always at least one bit wide.
    localparam int              HOLD_E   = (HOLD < 1) ? 1 : HOLD;
    localparam int              CW       = $clog2(HOLD_E + 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(HOLD_E);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [NCH-1:0] a;
    logic [NCH-1:0] a_nxt;
    logic [NCH-1:0] permit;
    logic [CW-1:0]  cnt     [NCH];
    logic [CW-1:0]  cnt_nxt [NCH];
    logic           all_rel;

`ifdef MAKE_RESET_SEQ_EN
    // A channel may only release once its lower neighbour is already released.
    always_comb begin
        permit    = '1;
        for (int unsigned i = 1; i < NCH; i++) begin
            permit[i] = ~a[i-1];
        end
    end
`else
    always_comb begin
        permit = '1;
    end
`endif

    always_comb begin
        a_nxt   = a;
        cnt_nxt = cnt;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (bus.ASSERT_IN[i]) begin
                a_nxt[i]   = 1'b1;
                cnt_nxt[i] = CNT_FULL;
            end else if (a[i]) begin
                if (cnt[i] <= CNT_ONE && permit[i]) begin
                    a_nxt[i]   = 1'b0;
                    cnt_nxt[i] = '0;
                end else if (cnt[i] > CNT_ONE) begin
                    cnt_nxt[i] = cnt[i] - CNT_ONE;
                end else begin
                    // Blocked by sequencing: park at 1 until permitted.
                    cnt_nxt[i] = CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a       <= INIT;
            all_rel <= (INIT == '0);
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i] <= INIT[i] ? CNT_FULL : '0;
            end
        end else begin
            a       <= a_nxt;
            all_rel <= (a_nxt == '0);
            cnt     <= cnt_nxt;
        end
    end

    assign bus.ASSERT_OUT   = a;
    assign bus.OUT_RST_N    = ~a;
    assign bus.ALL_RELEASED = all_rel;
endmodule
